// File: rtl/score_display_pkg.sv
// Shared types, mode codes and seven-segment patterns for the score display driver.
package score_display_pkg;

    localparam int unsigned SCORE_W = 13;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned ITER_W  = 4;

    // Double-dabble engine states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } convState_t;

    // DisplayScoreControl encodings
    localparam logic [1:0] MODE_BLANK = 2'b00;
    localparam logic [1:0] MODE_SCORE = 2'b01;
    localparam logic [1:0] MODE_DASH  = 2'b10;
    localparam logic [1:0] MODE_ERR   = 2'b11;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_E    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_R    = 7'b1010000;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

    // BCD nibble to active-high segment pattern; non-decimal codes go dark
    function automatic logic [SEG_W-1:0] bcdToSeg(input logic [3:0] nibble);
        logic [SEG_W-1:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/score_display_driver_bin2bcd13.sv
// Iterative 13-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
module bin2bcd13
    import score_display_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] value,
    output logic               busy,
    output logic               valid_c,
    output logic [BCD_W-1:0]   bcd,
    output logic [SCORE_W-1:0] sample
);

    localparam int unsigned NIBBLES = BCD_W / 4;
    localparam logic [ITER_W-1:0] ITER_LOAD = ITER_W'(SCORE_W);

    convState_t               state;
    convState_t               stateNext;
    logic                     loadEn;
    logic                     shiftEn;
    logic [SCORE_W-1:0]       binReg;
    logic [ITER_W-1:0]        iterCount;
    logic [BCD_W-1:0]         adjusted;
    logic [BCD_W+SCORE_W-1:0] shiftVec;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   if (iterCount == ITER_W'(1)) stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State decode into datapath strobes
    always_comb begin
        loadEn  = 1'b0;
        shiftEn = 1'b0;
        valid_c = 1'b0;
        case (state)
            IDLE:    loadEn  = start;
            SHIFT:   shiftEn = 1'b1;
            COMMIT:  valid_c = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every nibble >= 5, then form the pre-shift vector
    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shiftVec = {adjusted, binReg};
    end

    // Accumulator, operand shift register, iteration count and busy flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            binReg    <= '0;
            bcd       <= '0;
            sample    <= '0;
            iterCount <= '0;
            busy      <= 1'b0;
        end else if (loadEn) begin
            binReg    <= value;
            sample    <= value;
            bcd       <= '0;
            iterCount <= ITER_LOAD;
            busy      <= 1'b1;
        end else if (shiftEn) begin
            bcd       <= shiftVec[BCD_W+SCORE_W-2 : SCORE_W-1];
            binReg    <= {shiftVec[SCORE_W-2:0], 1'b0};
            iterCount <= iterCount - ITER_W'(1);
        end else if (valid_c) begin
            busy      <= 1'b0;
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// Reaction-time score display: BCD conversion, mode mux, leading-zero blanking and "Err" blink.
module score_display_driver
    import score_display_pkg::*;
#(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_HALF     = 25000000
)
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic [12:0]  DisplayScore,
    input  logic [1:0]   DisplayScoreControl,
    output logic [6:0]   Hex0,
    output logic [6:0]   Hex1,
    output logic [6:0]   Hex2,
    output logic [6:0]   Hex3,
    output logic         Busy
);

    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic               startConv;
    logic               engBusy;
    logic               engValid;
    logic [BCD_W-1:0]   engBcd;
    logic [SCORE_W-1:0] engSample;
    logic [BCD_W-1:0]   bcdLatch;
    logic [SCORE_W-1:0] lastConverted;
    logic [CNT_W-1:0]   blinkCount;
    logic               blinkOn;
    logic [SEG_W-1:0]   pat0;
    logic [SEG_W-1:0]   pat1;
    logic [SEG_W-1:0]   pat2;
    logic [SEG_W-1:0]   pat3;
    logic               lead1;
    logic               lead2;
    logic               lead3;

    // Map an active-high pattern onto the board's segment polarity
    function automatic logic [SEG_W-1:0] toPins(input logic [SEG_W-1:0] pat);
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

    assign startConv = (DisplayScore != lastConverted);
    assign Busy      = engBusy;

    bin2bcd13 u_bin2bcd13 (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (startConv),
        .value   (DisplayScore),
        .busy    (engBusy),
        .valid_c (engValid),
        .bcd     (engBcd),
        .sample  (engSample)
    );

    // Capture a finished conversion together with the value it came from
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bcdLatch      <= '0;
            lastConverted <= '0;
        end else if (engValid) begin
            bcdLatch      <= engBcd;
            lastConverted <= engSample;
        end
    end

    // Blink timebase: held cleared with phase on outside Err mode so Err shows at once
    always_ff @(posedge Clock) begin
        if (Reset || (DisplayScoreControl != MODE_ERR)) begin
            blinkCount <= '0;
            blinkOn    <= 1'b1;
        end else if (blinkCount == BLINK_LAST) begin
            blinkCount <= '0;
            blinkOn    <= ~blinkOn;
        end else begin
            blinkCount <= blinkCount + CNT_W'(1);
        end
    end

    // Mode mux with leading-zero blanking of the upper three digits
    always_comb begin
        pat0  = SEG_OFF;
        pat1  = SEG_OFF;
        pat2  = SEG_OFF;
        pat3  = SEG_OFF;
        lead3 = (bcdLatch[15:12] != 4'd0);
        lead2 = lead3 || (bcdLatch[11:8] != 4'd0);
        lead1 = lead2 || (bcdLatch[7:4] != 4'd0);
        case (DisplayScoreControl)
            MODE_BLANK: ;
            MODE_SCORE: begin
                pat0 = bcdToSeg(bcdLatch[3:0]);
                if (lead1) pat1 = bcdToSeg(bcdLatch[7:4]);
                if (lead2) pat2 = bcdToSeg(bcdLatch[11:8]);
                if (lead3) pat3 = bcdToSeg(bcdLatch[15:12]);
            end
            MODE_DASH: begin
                pat0 = SEG_DASH;
                pat1 = SEG_DASH;
                pat2 = SEG_DASH;
                pat3 = SEG_DASH;
            end
            MODE_ERR: begin
                if (blinkOn) begin
                    pat3 = SEG_E;
                    pat2 = SEG_R;
                    pat1 = SEG_R;
                end
            end
            default: ;
        endcase
    end

    // Output registers with polarity applied
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Hex0 <= toPins(SEG_OFF);
            Hex1 <= toPins(SEG_OFF);
            Hex2 <= toPins(SEG_OFF);
            Hex3 <= toPins(SEG_OFF);
        end else begin
            Hex0 <= toPins(pat0);
            Hex1 <= toPins(pat1);
            Hex2 <= toPins(pat2);
            Hex3 <= toPins(pat3);
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Directed self-checking bench for score_display_driver (active-low segments, BLINK_HALF = 4).
module tb_score_display_driver;

    localparam logic [6:0] L0   = 7'b1000000;
    localparam logic [6:0] L1   = 7'b1111001;
    localparam logic [6:0] L2   = 7'b0100100;
    localparam logic [6:0] L3   = 7'b0110000;
    localparam logic [6:0] L4   = 7'b0011001;
    localparam logic [6:0] L5   = 7'b0010010;
    localparam logic [6:0] L7   = 7'b1111000;
    localparam logic [6:0] L8   = 7'b0000000;
    localparam logic [6:0] L9   = 7'b0010000;
    localparam logic [6:0] LDSH = 7'b0111111;
    localparam logic [6:0] LE   = 7'b0000110;
    localparam logic [6:0] LR   = 7'b0101111;
    localparam logic [6:0] LOFF = 7'h7F;

    localparam logic [27:0] P_OFF  = {LOFF, LOFF, LOFF, LOFF};
    localparam logic [27:0] P_0    = {LOFF, LOFF, LOFF, L0};
    localparam logic [27:0] P_7    = {LOFF, LOFF, LOFF, L7};
    localparam logic [27:0] P_500  = {LOFF, L5, L0, L0};
    localparam logic [27:0] P_1000 = {L1, L0, L0, L0};
    localparam logic [27:0] P_1234 = {L1, L2, L3, L4};
    localparam logic [27:0] P_4321 = {L4, L3, L2, L1};
    localparam logic [27:0] P_8191 = {L8, L1, L9, L1};
    localparam logic [27:0] P_ERR  = {LE, LR, LR, LOFF};
    localparam logic [27:0] P_DASH = {LDSH, LDSH, LDSH, LDSH};

    logic        Clock;
    logic        Reset;
    logic [12:0] DisplayScore;
    logic [1:0]  DisplayScoreControl;
    logic [6:0]  Hex0;
    logic [6:0]  Hex1;
    logic [6:0]  Hex2;
    logic [6:0]  Hex3;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    score_display_driver #(
        .SEG_ACTIVE_LOW (1'b1),
        .BLINK_HALF     (4)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .DisplayScore        (DisplayScore),
        .DisplayScoreControl (DisplayScoreControl),
        .Hex0                (Hex0),
        .Hex1                (Hex1),
        .Hex2                (Hex2),
        .Hex3                (Hex3),
        .Busy                (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [27:0] observed, input logic [27:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [27:0] hexAll();
        return {Hex3, Hex2, Hex1, Hex0};
    endfunction

    initial begin
        int          busyCycles;
        logic [27:0] exp;

        Reset               = 1'b1;
        DisplayScore        = 13'd0;
        DisplayScoreControl = 2'b00;
        tick(2);
        check("reset_hex", hexAll(), P_OFF);
        check("reset_busy", 28'(Busy), 28'(0));
        Reset = 1'b0;

        // 1234: busy length, pre-commit display and 16-cycle latency
        DisplayScore        = 13'd1234;
        DisplayScoreControl = 2'b01;
        busyCycles          = 0;
        for (int t = 1; t <= 15; t++) begin
            tick(1);
            if (Busy === 1'b1) busyCycles++;
        end
        check("pre_commit_zero", hexAll(), P_0);
        tick(1);
        if (Busy === 1'b1) busyCycles++;
        check("busy_len", 28'(busyCycles), 28'(14));
        check("score_1234", hexAll(), P_1234);
        check("busy_idle", 28'(Busy), 28'(0));

        // Leading-zero blanking: 7 then 0
        DisplayScore = 13'd7;
        tick(16);
        check("score_7", hexAll(), P_7);
        DisplayScore = 13'd0;
        tick(16);
        check("score_0", hexAll(), P_0);

        // Maximum input
        DisplayScore = 13'd8191;
        tick(16);
        check("score_8191", hexAll(), P_8191);

        // Input change mid-conversion: 500 completes first, then 1000
        DisplayScore = 13'd500;
        for (int t = 1; t <= 31; t++) begin
            tick(1);
            if (t == 5) DisplayScore = 13'd1000;
            if (t <= 15)      exp = P_8191;
            else if (t <= 30) exp = P_500;
            else              exp = P_1000;
            check($sformatf("requeue_t%0d", t), hexAll(), exp);
            if (t == 15) check("busy_commit_gap", 28'(Busy), 28'(0));
            if (t == 16) check("busy_restart", 28'(Busy), 28'(1));
        end

        // Err blink with BLINK_HALF = 4
        DisplayScoreControl = 2'b11;
        for (int t = 1; t <= 12; t++) begin
            tick(1);
            exp = ((t >= 5) && (t <= 8)) ? P_OFF : P_ERR;
            check($sformatf("blink_t%0d", t), hexAll(), exp);
        end
        DisplayScoreControl = 2'b10;
        tick(1);
        check("mode_dash", hexAll(), P_DASH);
        DisplayScoreControl = 2'b00;
        tick(1);
        check("mode_blank", hexAll(), P_OFF);
        DisplayScoreControl = 2'b01;
        tick(1);
        check("mode_score_back", hexAll(), P_1000);

        // Reset mid-conversion of 4321
        DisplayScore = 13'd4321;
        tick(6);
        check("busy_mid", 28'(Busy), 28'(1));
        Reset = 1'b1;
        tick(1);
        check("abort_hex", hexAll(), P_OFF);
        check("abort_busy", 28'(Busy), 28'(0));
        Reset = 1'b0;
        tick(15);
        check("post_reset_zero", hexAll(), P_0);
        tick(1);
        check("score_4321", hexAll(), P_4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
